// File: rtl/mult_hilo_ctrl_if.sv
// Bundle of the EXE-side request/result signals and the multiplier-side
// handshake for mult_hilo_ctrl.
//
// Handshake semantics:
//   - A request transfers on a rising edge where req_valid & req_ready are
//     both high and flush is low. req_ready depends only on controller state,
//     never combinationally on req_valid.
//   - rd_valid is a one-cycle pulse; rd_data is meaningful only while it is
//     high.
//   - mult_begin is held high, with mult_op1/mult_op2 stable, until the
//     multiplier raises mult_end (or the operation is abandoned). Between
//     two operations mult_begin is low for at least one cycle.
interface mult_hilo_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_rs;
  logic [31:0] req_rt;
  logic        req_ready;
  logic        flush;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;

  // Controller view
  modport slave (
    input  req_valid, req_op, req_rs, req_rt, flush, product, mult_end,
    output req_ready, rd_valid, rd_data, hi, lo, mult_begin, mult_op1, mult_op2
  );

  // Pipeline + multiplier view
  modport master (
    output req_valid, req_op, req_rs, req_rt, flush, product, mult_end,
    input  req_ready, rd_valid, rd_data, hi, lo, mult_begin, mult_op1, mult_op2
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// HI/LO sequencing controller: owns the architectural HI/LO registers,
// executes MFHI/MFLO/MTHI/MTLO in one cycle and sequences MULT/MULTU through
// an external iterative signed multiplier, correcting its result for MULTU.
module mult_hilo_ctrl (
  input  logic             clk,
  input  logic             resetn,
  mult_hilo_ctrl_if.slave  bus,
  output logic             dbg_state_o
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MFHI  = 3'd2;
  localparam logic [2:0] OP_MFLO  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        uns_q, uns_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic        accept;
  logic [63:0] corr_prod;

  // A flush in IDLE cancels whatever the pipeline is presenting this cycle.
  assign accept = (state_q == S_IDLE) & bus.req_valid & ~bus.flush;

  // The multiplier treats both operands as signed. For MULTU, each operand
  // whose top bit is set was read as (x - 2^32); adding the other operand
  // shifted left by 32 restores the unsigned product modulo 2^64.
  assign corr_prod = bus.product
                   + ((uns_q & op1_q[31]) ? {op2_q, 32'b0} : 64'd0)
                   + ((uns_q & op2_q[31]) ? {op1_q, 32'b0} : 64'd0);

  // Next-state and register-update logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    uns_d      = uns_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_MULT, OP_MULTU: begin
              op1_d   = bus.req_rs;
              op2_d   = bus.req_rt;
              uns_d   = (bus.req_op == OP_MULTU);
              state_d = S_RUN;
            end
            OP_MFHI: begin
              rd_data_d  = hi_q;
              rd_valid_d = 1'b1;
            end
            OP_MFLO: begin
              rd_data_d  = lo_q;
              rd_valid_d = 1'b1;
            end
            OP_MTHI: hi_d = bus.req_rs;
            OP_MTLO: lo_d = bus.req_rs;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // flush wins over a same-cycle mult_end: the product is discarded.
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.mult_end) begin
          {hi_d, lo_d} = corr_prod;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      op1_q      <= 32'd0;
      op2_q      <= 32'd0;
      uns_q      <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      uns_q      <= uns_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // mult_begin is high exactly while in RUN, so returning to IDLE always
  // gives the multiplier one begin-low cycle before any reload.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mult_begin = (state_q == S_RUN);
  assign bus.mult_op1   = op1_q;
  assign bus.mult_op2   = op2_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign dbg_state_o    = state_q;

endmodule
